// File: rtl/prog_counter.sv
// prog_counter: loadable, programmable-modulo up/down counter with an
// IDLE/RUN/DONE control FSM, free-running or one-shot, and a registered
// single-cycle terminal-count pulse.
// Optional step prescaler enabled by defining PROG_COUNTER_PRESCALE_EN.
module prog_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] modulo,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2) begin : g_bad_width
    $error("prog_counter: WIDTH must be at least 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("prog_counter: PRESCALE must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] last_val;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;
  logic             step_en;

  // M-1; modulo == 0 wraps naturally to all-ones, i.e. 2^WIDTH - 1
  assign last_val     = modulo - WIDTH'(1);
  assign load_clamped = ((modulo != '0) && (load_val >= modulo)) ? '0 : load_val;
  assign at_term      = up ? (count_q >= last_val) : (count_q == '0);

`ifdef PROG_COUNTER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign step_en = (pre_q == PW'(PRESCALE - 1));

  // Prescaler advances only while running; any exit from RUN leaves it at 0
  always_comb begin
    pre_d = '0;
    if ((state_q == S_RUN) && (load || !stop)) begin
      pre_d = step_en ? '0 : pre_q + PW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end
`else
  assign step_en = 1'b1;
`endif

  // Next state, next count and terminal pulse; load > stop > start > step
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            count_d = up ? '0 : last_val;
          end
        end
        S_RUN: begin
          if (step_en) begin
            if (at_term) begin
              tc_d = 1'b1;
              if (oneshot) state_d = S_DONE;
              else         count_d = up ? '0 : last_val;
            end else begin
              count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, count and pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model.
module tb_prog_counter;
  localparam int WIDTH = 8;
`ifdef PROG_COUNTER_PRESCALE_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 1;
`endif
  localparam int MS_IDLE = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_DONE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, load, up, oneshot;
  logic [WIDTH-1:0] load_val, modulo;
  logic [WIDTH-1:0] count;
  logic             tc, busy, done;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_count = 0;
  int m_state = MS_IDLE;
  int m_pre   = 0;
  bit m_tc    = 1'b0;

  prog_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .up(up), .oneshot(oneshot), .modulo(modulo),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the model from the inputs applied now
  task automatic tick();
    int  m, nc, ns, np;
    bit  ntc, term;
    m   = (modulo == 0) ? (1 << WIDTH) : int'(modulo);
    nc  = m_count;
    ns  = m_state;
    np  = 0;
    ntc = 1'b0;
    if (rst) begin
      if (m_state == MS_RUN && (load || !stop)) np = (m_pre + 1) % PRE;
      if (load) begin
        nc = (int'(load_val) >= m) ? 0 : int'(load_val);
      end else if (stop) begin
        ns = MS_IDLE;
      end else if (m_state == MS_IDLE) begin
        if (start) ns = MS_RUN;
      end else if (m_state == MS_DONE) begin
        if (start) begin
          ns = MS_RUN;
          nc = up ? 0 : m - 1;
        end
      end else if (m_pre == PRE - 1) begin
        term = up ? (m_count >= m - 1) : (m_count == 0);
        if (term) begin
          ntc = 1'b1;
          if (oneshot) ns = MS_DONE;
          else         nc = up ? 0 : m - 1;
        end else begin
          nc = (up ? m_count + 1 : m_count - 1) % (1 << WIDTH);
        end
      end
    end else begin
      nc = 0;
      ns = MS_IDLE;
    end
    @(posedge clk);
    #1;
    m_count = nc;
    m_state = ns;
    m_pre   = np;
    m_tc    = ntc;
  endtask

  task automatic go_idle();
    rst = 1'b1; start = 1'b0; load = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; stop = 1'b0; load = 1'b0;
    up = 1'b1; oneshot = 1'b0; modulo = 8'd10; load_val = 8'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({count, tc, busy, done} !== {8'd0, 3'b000}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, {count, tc, busy, done}, {8'd0, 3'b000});
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({count, busy, done} !== {8'd0, 2'b10}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {count, busy, done}, {8'd0, 2'b10});
    end
    go_idle();
  endtask

  task automatic test_free_run_wrap();
    go_idle();
    modulo = 8'd10; up = 1'b1; oneshot = 1'b0; load_val = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if ({count, tc, busy, done} !== {8'(k % 10), (k % 10) == 0, 2'b10}) begin
        errors++;
        $display("FAIL free_run[%0d]: got %h expected %h", k, {count, tc, busy, done},
                 {8'(k % 10), (k % 10) == 0, 2'b10});
      end
    end
    go_idle();
  endtask

  task automatic test_down_oneshot();
    logic [10:0] exp_v [7];
    exp_v[0] = {8'd3, 3'b000};  // after load in IDLE
    exp_v[1] = {8'd3, 3'b010};  // start
    exp_v[2] = {8'd2, 3'b010};
    exp_v[3] = {8'd1, 3'b010};
    exp_v[4] = {8'd0, 3'b010};
    exp_v[5] = {8'd0, 3'b101};  // terminal: tc + DONE
    exp_v[6] = {8'd0, 3'b001};
    go_idle();
    modulo = 8'd5; up = 1'b0; oneshot = 1'b1; load_val = 8'd3;
    for (int i = 0; i < 7; i++) begin
      load  = (i == 0);
      start = (i == 1);
      tick();
      checks++;
      if ({count, tc, busy, done} !== exp_v[i]) begin
        errors++;
        $display("FAIL down_oneshot[%0d]: got %h expected %h", i, {count, tc, busy, done}, exp_v[i]);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({count, tc, busy, done} !== {8'd4, 3'b010}) begin
      errors++;
      $display("FAIL down_restart: got %h expected %h", {count, tc, busy, done}, {8'd4, 3'b010});
    end
    go_idle();
  endtask

  task automatic test_full_range_clamp();
    logic [10:0] exp_v [4];
    exp_v[0] = {8'd254, 3'b000};
    exp_v[1] = {8'd254, 3'b010};
    exp_v[2] = {8'd255, 3'b010};
    exp_v[3] = {8'd0,   3'b110};
    go_idle();
    modulo = 8'd0; up = 1'b1; oneshot = 1'b0; load_val = 8'd254;
    for (int i = 0; i < 4; i++) begin
      load  = (i == 0);
      start = (i == 1);
      tick();
      checks++;
      if ({count, tc, busy, done} !== exp_v[i]) begin
        errors++;
        $display("FAIL full_range[%0d]: got %h expected %h", i, {count, tc, busy, done}, exp_v[i]);
      end
    end
    go_idle();
    modulo = 8'd10; load_val = 8'd12; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL load_clamp: got %0d expected 0", count);
    end
  endtask

  task automatic test_simultaneous();
    go_idle();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL start_stop_idle: got %b expected 00", {busy, done});
    end
    modulo = 8'd3; up = 1'b1; oneshot = 1'b0; load_val = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();  // count now 2, next step terminal
    load = 1'b1; load_val = 8'd1;
    tick();
    load = 1'b0;
    checks++;
    if ({count, tc, busy, done} !== {8'd1, 3'b010}) begin
      errors++;
      $display("FAIL load_at_terminal: got %h expected %h", {count, tc, busy, done}, {8'd1, 3'b010});
    end
    tick();  // count 2
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({count, tc, busy, done} !== {8'd2, 3'b000}) begin
      errors++;
      $display("FAIL stop_at_terminal: got %h expected %h", {count, tc, busy, done}, {8'd2, 3'b000});
    end
  endtask

  task automatic test_oneshot_m1();
    go_idle();
    modulo = 8'd1; up = 1'b1; oneshot = 1'b1; load_val = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({count, tc, busy, done} !== {8'd0, 3'b010}) begin
      errors++;
      $display("FAIL m1_entry: got %h expected %h", {count, tc, busy, done}, {8'd0, 3'b010});
    end
    tick();
    checks++;
    if ({count, tc, busy, done} !== {8'd0, 3'b101}) begin
      errors++;
      $display("FAIL m1_done: got %h expected %h", {count, tc, busy, done}, {8'd0, 3'b101});
    end
    go_idle();
  endtask

`ifdef PROG_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    int ec;
    go_idle();
    modulo = 8'd3; up = 1'b1; oneshot = 1'b0; load_val = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      ec = (e / 4) % 3;
      checks++;
      if ({count, tc} !== {8'(ec), e == 12}) begin
        errors++;
        $display("FAIL prescale[%0d]: got %h expected %h", e, {count, tc}, {8'(ec), e == 12});
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (count !== 8'(e / 4)) begin
        errors++;
        $display("FAIL prescale_restart[%0d]: got %0d expected %0d", e, count, e / 4);
      end
    end
    go_idle();
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] mod_pick [6];
    mod_pick[0] = 8'd0; mod_pick[1] = 8'd1; mod_pick[2] = 8'd2;
    mod_pick[3] = 8'd5; mod_pick[4] = 8'd10; mod_pick[5] = 8'd37;
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      load  = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 63) == 0) modulo = mod_pick[$urandom_range(0, 5)];
      tick();
      checks++;
      if ({count, tc, busy, done} !==
          {8'(m_count), m_tc, m_state == MS_RUN, m_state == MS_DONE}) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", c, {count, tc, busy, done},
                 {8'(m_count), m_tc, m_state == MS_RUN, m_state == MS_DONE});
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_free_run_wrap();
    test_down_oneshot();
    test_full_range_clamp();
    test_simultaneous();
    test_oneshot_m1();
`ifdef PROG_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
